// File: rtl/alu_shift_seq.sv
// Shift-instruction sequencer: owns the ALU for one RLC/RRC/RL/RR/SLA/SRA/SWAP/SRL
// request, steps it through LOAD and RESULT, and returns byte + flags on a valid/ready port.
module alu_shift_seq #(
  parameter bit HOLD_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  input  logic       req_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_z,
  output logic       rsp_n,
  output logic       rsp_h,
  output logic       rsp_c,
  output logic [7:0] alu_op,
  output logic       alu_si,
  output logic [1:0] alu_sh,
  output logic [1:0] alu_oe,
  output logic [1:0] alu_la,
  output logic [1:0] alu_lb,
  output logic       alu_r,
  output logic       alu_s,
  output logic       alu_v,
  output logic       alu_ne,
  output logic       alu_ci,
  output logic       alu_l,
  output logic       alu_h,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_shift_dbl
);

  // state  | meaning
  // IDLE   | ready for a request, ALU released
  // LOAD   | operand on bus, shifter selected, shifted-out bit captured as C
  // RESULT | shifter result enabled onto output, result and Z captured
  // DONE   | response valid, waiting for rsp_ready

  // ALU control encodings (shared with alu.svh)
  localparam logic [1:0] L_SH    = 2'b01;
  localparam logic [1:0] R_SH    = 2'b10;
  localparam logic [1:0] SWAP_SH = 2'b11;
  localparam logic [1:0] SH_OE   = 2'b01;
  localparam logic [1:0] RES_OE  = 2'b10;
  localparam logic [1:0] BUS_LD  = 2'b01;
  localparam logic [1:0] NO_LD   = 2'b11;

  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  typedef enum logic [1:0] {IDLE, LOAD, RESULT, DONE} state_t;

  typedef struct packed {
    logic [7:0] op;
    logic       si;
    logic [1:0] sh;
    logic [1:0] oe;
    logic [1:0] la;
    logic [1:0] lb;
    logic       r, s, v, ne, ci, l, h;
  } alu_ctl_t;

  localparam alu_ctl_t CTL_IDLE = '{8'h00, 1'b0, 2'b00, 2'b00, NO_LD, NO_LD,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  state_t   state, state_nxt;
  alu_ctl_t ctl_q, ctl_nxt;
  logic     swap_q;
  logic [1:0] sh_dec;
  logic       si_dec;

  always_comb begin
    sh_dec = L_SH;
    si_dec = 1'b0;
    case (req_op)
      OP_RLC:  begin sh_dec = L_SH;    si_dec = req_data[7]; end
      OP_RRC:  begin sh_dec = R_SH;    si_dec = req_data[0]; end
      OP_RL:   begin sh_dec = L_SH;    si_dec = req_c;       end
      OP_RR:   begin sh_dec = R_SH;    si_dec = req_c;       end
      OP_SLA:  begin sh_dec = L_SH;    si_dec = 1'b0;        end
      OP_SRA:  begin sh_dec = R_SH;    si_dec = req_data[7]; end
      OP_SWAP: begin sh_dec = SWAP_SH; si_dec = 1'b0;        end
      OP_SRL:  begin sh_dec = R_SH;    si_dec = 1'b0;        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // ALU controls are registered from the next state so each phase's values
  // are stable for its whole cycle.
  always_comb begin
    state_nxt = state;
    ctl_nxt   = ctl_q;
    case (state)
      IDLE: begin
        if (HOLD_IDLE) ctl_nxt = CTL_IDLE;
        if (req_valid) begin
          state_nxt = LOAD;
          ctl_nxt   = '{req_data, si_dec, sh_dec, SH_OE, BUS_LD, BUS_LD,
                        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        end
      end
      LOAD: begin
        state_nxt = RESULT;
        ctl_nxt.oe = RES_OE;
        ctl_nxt.la = NO_LD;
        ctl_nxt.lb = NO_LD;
        ctl_nxt.l  = 1'b0;
        ctl_nxt.h  = 1'b1;
      end
      RESULT: begin
        state_nxt = DONE;
        if (HOLD_IDLE) ctl_nxt = CTL_IDLE;
      end
      DONE: begin
        if (HOLD_IDLE) ctl_nxt = CTL_IDLE;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ctl_q     <= CTL_IDLE;
      swap_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_z     <= 1'b0;
      rsp_c     <= 1'b0;
    end else begin
      ctl_q <= ctl_nxt;
      case (state)
        IDLE:   if (req_valid) swap_q <= (req_op == OP_SWAP);
        LOAD:   rsp_c <= swap_q ? 1'b0 : alu_shift_dbl;
        RESULT: begin
          rsp_data  <= alu_result;
          rsp_z     <= alu_zero;
          rsp_valid <= 1'b1;
        end
        DONE:   if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_n     = 1'b0;
  assign rsp_h     = 1'b0;

  assign alu_op = ctl_q.op;
  assign alu_si = ctl_q.si;
  assign alu_sh = ctl_q.sh;
  assign alu_oe = ctl_q.oe;
  assign alu_la = ctl_q.la;
  assign alu_lb = ctl_q.lb;
  assign alu_r  = ctl_q.r;
  assign alu_s  = ctl_q.s;
  assign alu_v  = ctl_q.v;
  assign alu_ne = ctl_q.ne;
  assign alu_ci = ctl_q.ci;
  assign alu_l  = ctl_q.l;
  assign alu_h  = ctl_q.h;

  a_z_matches_data: assert property (@(posedge clk) disable iff (!nreset)
    (state == DONE) |-> (rsp_z == (rsp_data == 8'h00)));

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a small behavioural shifter standing in for the ALU.
module tb_alu_shift_seq;

  localparam logic [1:0] L_SH    = 2'b01;
  localparam logic [1:0] R_SH    = 2'b10;
  localparam logic [1:0] SWAP_SH = 2'b11;
  localparam logic [1:0] SH_OE   = 2'b01;
  localparam logic [1:0] RES_OE  = 2'b10;
  localparam logic [1:0] BUS_LD  = 2'b01;
  localparam logic [1:0] NO_LD   = 2'b11;

  logic clk = 1'b0;
  logic nreset;
  logic req_valid, req_ready, req_c;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic rsp_valid, rsp_ready, rsp_z, rsp_n, rsp_h, rsp_c;
  logic [7:0] rsp_data, alu_op, alu_result;
  logic alu_si, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
  logic [1:0] alu_sh, alu_oe, alu_la, alu_lb;
  logic alu_zero, alu_shift_dbl;

  int checks = 0;
  int errors = 0;

  alu_shift_seq dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_h(rsp_h), .rsp_c(rsp_c),
    .alu_op(alu_op), .alu_si(alu_si), .alu_sh(alu_sh), .alu_oe(alu_oe),
    .alu_la(alu_la), .alu_lb(alu_lb), .alu_r(alu_r), .alu_s(alu_s),
    .alu_v(alu_v), .alu_ne(alu_ne), .alu_ci(alu_ci), .alu_l(alu_l),
    .alu_h(alu_h), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_shift_dbl(alu_shift_dbl)
  );

  always #5 clk = ~clk;

  // Shifter stand-in; for SWAP the shifted-out bit is op[7] so the DUT must ignore it.
  always_comb begin
    alu_result    = alu_op;
    alu_shift_dbl = 1'b0;
    case (alu_sh)
      L_SH:    begin alu_result = {alu_op[6:0], alu_si}; alu_shift_dbl = alu_op[7]; end
      R_SH:    begin alu_result = {alu_si, alu_op[7:1]}; alu_shift_dbl = alu_op[0]; end
      SWAP_SH: begin alu_result = {alu_op[3:0], alu_op[7:4]}; alu_shift_dbl = alu_op[7]; end
      default: ;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; 'stall' cycles of rsp_ready=0 in DONE with a new req_valid pending.
  task automatic run_op(input logic [2:0] op, input logic [7:0] data, input logic c,
                        input logic [1:0] exp_sh, input logic exp_si,
                        input logic [7:0] exp_data, input logic exp_z, input logic exp_c,
                        input int stall);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = data; req_c = c;
    check("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("load_op", alu_op, data);
    check("load_si", alu_si, exp_si);
    check("load_sh", alu_sh, exp_sh);
    check("load_ctl", {alu_la, alu_lb, alu_oe, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h},
          {BUS_LD, BUS_LD, SH_OE, 7'b1110010});
    check("load_ready", req_ready, 0);
    @(posedge clk); #1;
    check("res_ctl", {alu_la, alu_lb, alu_oe, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h},
          {NO_LD, NO_LD, RES_OE, 7'b1110001});
    check("res_hold", {alu_op, alu_si, alu_sh}, {data, exp_si, exp_sh});
    check("res_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("done_valid", rsp_valid, 1);
    check("done_data", rsp_data, exp_data);
    check("done_flags", {rsp_z, rsp_n, rsp_h, rsp_c}, {exp_z, 1'b0, 1'b0, exp_c});
    check("done_idle_ctl", {alu_op, alu_la, alu_lb, alu_oe, alu_l, alu_h},
          {8'h00, NO_LD, NO_LD, 2'b00, 1'b0, 1'b0});
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_op = 3'd4; req_data = 8'h3C;
      @(posedge clk); #1;
      check("stall_rsp", {rsp_valid, rsp_data, rsp_z, rsp_c}, {1'b1, exp_data, exp_z, exp_c});
      check("stall_ready", req_ready, 0);
      check("stall_no_load", alu_la, NO_LD);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("rel_valid", rsp_valid, 0);
    check("rel_ready", req_ready, 1);
    check("rel_no_accept", alu_la, NO_LD);
  endtask

  initial begin
    logic seen;
    nreset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00; req_c = 1'b0;
    rsp_ready = 1'b0;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_data, rsp_z, rsp_n, rsp_h, rsp_c}, 13'h0);
    check("rst_alu", {alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb,
                      alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h},
          {8'h00, 1'b0, 2'b00, 2'b00, NO_LD, NO_LD, 7'b0});
    @(negedge clk); nreset = 1'b1;

    //     op    data   c     sh       si    result z     c
    run_op(3'd3, 8'h01, 1'b0, R_SH,    1'b0, 8'h00, 1'b1, 1'b1, 0); // RR
    run_op(3'd3, 8'hA5, 1'b1, R_SH,    1'b1, 8'hD2, 1'b0, 1'b1, 0); // RR
    run_op(3'd0, 8'h80, 1'b0, L_SH,    1'b1, 8'h01, 1'b0, 1'b1, 0); // RLC
    run_op(3'd1, 8'h01, 1'b0, R_SH,    1'b1, 8'h80, 1'b0, 1'b1, 0); // RRC
    run_op(3'd2, 8'h40, 1'b1, L_SH,    1'b1, 8'h81, 1'b0, 1'b0, 0); // RL
    run_op(3'd5, 8'h81, 1'b0, R_SH,    1'b1, 8'hC0, 1'b0, 1'b1, 0); // SRA
    run_op(3'd7, 8'h81, 1'b1, R_SH,    1'b0, 8'h40, 1'b0, 1'b1, 0); // SRL
    run_op(3'd4, 8'h80, 1'b1, L_SH,    1'b0, 8'h00, 1'b1, 1'b1, 0); // SLA
    run_op(3'd6, 8'hF0, 1'b1, SWAP_SH, 1'b0, 8'h0F, 1'b0, 1'b0, 0); // SWAP
    run_op(3'd4, 8'h21, 1'b0, L_SH,    1'b0, 8'h42, 1'b0, 1'b0, 5); // SLA, stalled

    // Reset pulse during RESULT aborts the operation.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_data = 8'h01; req_c = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_res", alu_oe, RES_OE);
    nreset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_alu", {alu_op, alu_oe, alu_la, alu_lb, alu_r, alu_h},
          {8'h00, 2'b00, NO_LD, NO_LD, 1'b0, 1'b0});
    check("mid_rst_rsp", {rsp_valid, rsp_data, rsp_c}, 10'h0);
    @(negedge clk); nreset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    check("post_rst_no_valid", seen, 0);
    run_op(3'd6, 8'h5A, 1'b0, SWAP_SH, 1'b0, 8'hA5, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
